// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Bundles the signals exchanged between the pipeline datapath and the hazard
// controller: the source/destination indices and control bits held in the
// pipeline registers, the memory/branch status from the EX/MEM stage, and the
// PC/pipeline-register enables and flushes returned by the controller.
//
// Modports
//   master : pipeline side. Drives the hazard inputs and receives the
//            enables/flushes.
//   slave  : controller side. Receives the hazard inputs and drives the
//            enables/flushes.
//
// Signals
//   id_Rm, id_Rn, id_Sm, id_Sn  [2:0] source indices in IF/ID
//   ex_memRead                        ID/EX instruction is a load
//   ex_R_regWrite, ex_S_regWrite      ID/EX writes the R / S register file
//   ex_Rd, ex_Sd                [2:0] ID/EX destination indices
//   mem_branchTaken                   EX/MEM branch resolved taken
//   mem_busy                          data memory not ready
//   pcWrite                           PC load enable
//   p0_we..p3_we                      IF/ID, ID/EX, EX/MEM, MEM/WB enables
//   p0_flush..p2_flush                IF/ID, ID/EX, EX/MEM synchronous zeroing
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  logic [2:0] id_Rm;
  logic [2:0] id_Rn;
  logic [2:0] id_Sm;
  logic [2:0] id_Sn;
  logic       ex_memRead;
  logic       ex_R_regWrite;
  logic       ex_S_regWrite;
  logic [2:0] ex_Rd;
  logic [2:0] ex_Sd;
  logic       mem_branchTaken;
  logic       mem_busy;
  logic       pcWrite;
  logic       p0_we;
  logic       p1_we;
  logic       p2_we;
  logic       p3_we;
  logic       p0_flush;
  logic       p1_flush;
  logic       p2_flush;

  modport master (
    output id_Rm, id_Rn, id_Sm, id_Sn,
    output ex_memRead, ex_R_regWrite, ex_S_regWrite, ex_Rd, ex_Sd,
    output mem_branchTaken, mem_busy,
    input  pcWrite, p0_we, p1_we, p2_we, p3_we,
    input  p0_flush, p1_flush, p2_flush
  );

  modport slave (
    input  id_Rm, id_Rn, id_Sm, id_Sn,
    input  ex_memRead, ex_R_regWrite, ex_S_regWrite, ex_Rd, ex_Sd,
    input  mem_branchTaken, mem_busy,
    output pcWrite, p0_we, p1_we, p2_we, p3_we,
    output p0_flush, p1_flush, p2_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a 5-stage pipeline with two register files (R and S).
// Handles, in priority order:
//   1. memory freeze   (mem_busy)         - whole pipeline and PC hold
//   2. branch redirect (taken or latched) - flush IF/ID, ID/EX, EX/MEM
//   3. load-use bubble                    - hold PC and IF/ID, zero ID/EX
//   4. normal advance
// A branch that resolves while memory is busy is remembered in WAIT_BR and
// redirected in the first non-busy cycle.  Also keeps a saturating count of
// stalled cycles and a sticky flag for excessively long memory waits.
//
// Parameters
//   TIMEOUT      consecutive mem_busy cycles that set mem_timeout (2..31)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   hz           hazard interface, slave side
//   clr_stats    synchronous clear of stall_cnt and mem_timeout
//   state        current FSM state (RUN/WAIT/WAIT_BR/RECOVER)
//   stall_cnt    saturating count of cycles with pcWrite=0
//   mem_timeout  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz,
  input  logic                   clr_stats,
  output logic [1:0]             state,
  output logic [15:0]            stall_cnt,
  output logic                   mem_timeout
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT    = 2'b01,
    WAIT_BR = 2'b10,
    RECOVER = 2'b11
  } state_t;

  // busyRun saturates at TO_MAX; the flag is raised on the edge that takes it
  // from TO_MAX-1 to TO_MAX, so a saturated counter does not re-raise it.
  localparam logic [4:0] TO_MAX   = 5'(TIMEOUT);
  localparam logic [4:0] TO_REACH = 5'(TIMEOUT - 1);

  state_t      curState;
  state_t      nextState;
  logic [4:0]  busyRun;
  logic        luHit;
  logic        branchPending;
  logic        busyReach;

  logic        pcWriteC;
  logic [3:0]  weC;      // {p3, p2, p1, p0}
  logic [2:0]  flushC;   // {p2, p1, p0}

  // Saturating increment of the stall counter.
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  // Saturating increment of the consecutive-busy counter.
  function automatic logic [4:0] busyInc(input logic [4:0] v);
    if (v >= TO_MAX) begin
      return TO_MAX;
    end
    return v + 5'd1;
  endfunction

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  assign luHit = hz.ex_memRead &
                 ((hz.ex_R_regWrite & ((hz.ex_Rd == hz.id_Rm) | (hz.ex_Rd == hz.id_Rn))) |
                  (hz.ex_S_regWrite & ((hz.ex_Sd == hz.id_Sm) | (hz.ex_Sd == hz.id_Sn))));

  // A redirect is due either for a branch resolving now or one latched
  // during an earlier freeze (even if mem_branchTaken has since dropped).
  assign branchPending = (curState == WAIT_BR) | hz.mem_branchTaken;

  assign busyReach = hz.mem_busy & (busyRun == TO_REACH);

  // -------------------------------------------------------------------------
  // Next state and pipeline controls
  // -------------------------------------------------------------------------
  always_comb begin
    pcWriteC  = 1'b1;
    weC       = 4'b1111;
    flushC    = 3'b000;
    nextState = RUN;

    if (hz.mem_busy) begin
      // Freeze everything; flushing now would destroy the stalled load.
      pcWriteC  = 1'b0;
      weC       = 4'b0000;
      flushC    = 3'b000;
      nextState = branchPending ? WAIT_BR : WAIT;
    end else if (branchPending) begin
      pcWriteC  = 1'b1;
      weC       = 4'b1111;
      flushC    = 3'b111;
      nextState = RECOVER;
    end else if (luHit && (curState != RECOVER)) begin
      // After a redirect the IF/ID fields are zero and would falsely match
      // a load writing index 0, hence the RECOVER exclusion.
      // The bubble goes into ID/EX; on the next cycle the load has moved on,
      // so the hit clears and exactly one bubble is inserted.
      pcWriteC  = 1'b0;
      weC       = 4'b1110;
      flushC    = 3'b010;
      nextState = RUN;
    end
  end

  assign hz.pcWrite  = pcWriteC;
  assign hz.p0_we    = weC[0];
  assign hz.p1_we    = weC[1];
  assign hz.p2_we    = weC[2];
  assign hz.p3_we    = weC[3];
  assign hz.p0_flush = flushC[0];
  assign hz.p1_flush = flushC[1];
  assign hz.p2_flush = flushC[2];

  assign state = curState;

  // -------------------------------------------------------------------------
  // State register (reset drops any latched branch)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState <= RUN;
    end else begin
      curState <= nextState;
    end
  end

  // -------------------------------------------------------------------------
  // Statistics: stall counter, busy run length, timeout flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (!pcWriteC) begin
      stall_cnt <= satInc16(stall_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busyRun <= '0;
    end else if (hz.mem_busy) begin
      busyRun <= busyInc(busyRun);
    end else begin
      busyRun <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_timeout <= 1'b0;
    end else if (clr_stats) begin
      mem_timeout <= 1'b0;
    end else if (busyReach) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Each test task drives one scenario.  Per-cycle control outputs are checked
// by a scoreboard: the expected {pcWrite, we, flush, state} vector is queued
// when a cycle's stimulus is applied and compared at the following negedge.
// Registered statistics are checked inline by the tasks themselves.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  localparam int TIMEOUT = 16;

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_WAIT    = 2'b01;
  localparam logic [1:0] S_WAIT_BR = 2'b10;
  localparam logic [1:0] S_RECOVER = 2'b11;

  // {pcWrite, p3_we, p2_we, p1_we, p0_we, p2_flush, p1_flush, p0_flush}
  localparam logic [7:0] C_NORMAL = 8'b1_1111_000;
  localparam logic [7:0] C_FREEZE = 8'b0_0000_000;
  localparam logic [7:0] C_BUBBLE = 8'b0_1110_010;
  localparam logic [7:0] C_REDIR  = 8'b1_1111_111;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_stats;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hz),
    .clr_stats   (clr_stats),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ctl;
    logic [1:0] st;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monExp;
  logic [9:0]  monAct;
  int          sbCycle = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          expStall = 0;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clearInputs();
    hz.id_Rm = 3'd0; hz.id_Rn = 3'd0; hz.id_Sm = 3'd0; hz.id_Sn = 3'd0;
    hz.ex_memRead = 1'b0; hz.ex_R_regWrite = 1'b0; hz.ex_S_regWrite = 1'b0;
    hz.ex_Rd = 3'd0; hz.ex_Sd = 3'd0;
    hz.mem_branchTaken = 1'b0; hz.mem_busy = 1'b0;
    clr_stats = 1'b0;
  endtask

  // Queue the expectation for the cycle whose inputs are now applied, then
  // advance to just after the next rising edge.
  task automatic tick(input logic [7:0] ctl, input logic [1:0] st);
    exp_t e;
    e.ctl = ctl;
    e.st  = st;
    sbQ.push_back(e);
    if (ctl[7] == 1'b0 && expStall < 65535) expStall++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clearInputs();
    #1;
    checks++;
    if (state !== S_RUN) begin
      errors++; $display("FAIL reset_state got %b expected %b", state, S_RUN);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall got %0d expected 0", stall_cnt);
    end
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout got %b expected 0", mem_timeout);
    end
    @(posedge clk);
    #1;
    tick(C_NORMAL, S_RUN);   // outputs follow normal while held in reset
    reset = 1'b1;
    tick(C_NORMAL, S_RUN);
  endtask

  task automatic test_load_use();
    // R hit through id_Rn
    hz.ex_memRead = 1'b1; hz.ex_R_regWrite = 1'b1; hz.ex_Rd = 3'd3;
    hz.id_Rn = 3'd3; hz.id_Rm = 3'd5;
    tick(C_BUBBLE, S_RUN);
    hz.ex_memRead = 1'b0;    // bubble now sits in ID/EX
    tick(C_NORMAL, S_RUN);
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL loaduse_stall got %0d expected 1", stall_cnt);
    end
    // R hit through id_Rm
    hz.ex_memRead = 1'b1; hz.ex_Rd = 3'd6; hz.id_Rm = 3'd6; hz.id_Rn = 3'd0;
    tick(C_BUBBLE, S_RUN);
    // S hit through id_Sn; R side still matches but R write disabled
    hz.ex_R_regWrite = 1'b0; hz.ex_S_regWrite = 1'b1; hz.ex_Sd = 3'd2;
    hz.id_Sn = 3'd2; hz.id_Sm = 3'd7;
    tick(C_BUBBLE, S_RUN);
    // matches but not a load
    hz.ex_memRead = 1'b0; hz.ex_R_regWrite = 1'b1;
    tick(C_NORMAL, S_RUN);
    // load with both write enables off
    hz.ex_memRead = 1'b1; hz.ex_R_regWrite = 1'b0; hz.ex_S_regWrite = 1'b0;
    tick(C_NORMAL, S_RUN);
    // load writing registers nobody reads
    hz.ex_R_regWrite = 1'b1; hz.ex_S_regWrite = 1'b1;
    hz.ex_Rd = 3'd4; hz.ex_Sd = 3'd1;
    hz.id_Rm = 3'd5; hz.id_Rn = 3'd6; hz.id_Sm = 3'd7; hz.id_Sn = 3'd2;
    tick(C_NORMAL, S_RUN);
    clearInputs();
    checks++;
    if (stall_cnt !== 16'(expStall)) begin
      errors++; $display("FAIL loaduse_total got %0d expected %0d", stall_cnt, expStall);
    end
  endtask

  task automatic test_branch();
    hz.mem_branchTaken = 1'b1;
    tick(C_REDIR, S_RUN);
    // zeroed IF/ID matching a load to index 0: ignored in RECOVER
    hz.mem_branchTaken = 1'b0;
    hz.ex_memRead = 1'b1; hz.ex_R_regWrite = 1'b1; hz.ex_Rd = 3'd0;
    tick(C_NORMAL, S_RECOVER);
    // the same match one cycle later is a real hazard again
    tick(C_BUBBLE, S_RUN);
    clearInputs();
    tick(C_NORMAL, S_RUN);
    // branch outranks a simultaneous load-use hit
    hz.mem_branchTaken = 1'b1;
    hz.ex_memRead = 1'b1; hz.ex_R_regWrite = 1'b1; hz.ex_Rd = 3'd2; hz.id_Rm = 3'd2;
    tick(C_REDIR, S_RUN);
    clearInputs();
    tick(C_NORMAL, S_RECOVER);
    tick(C_NORMAL, S_RUN);
  endtask

  task automatic test_busy_branch();
    int s0;
    s0 = expStall;
    hz.mem_busy = 1'b1; hz.mem_branchTaken = 1'b1;
    tick(C_FREEZE, S_RUN);
    hz.mem_branchTaken = 1'b0;
    tick(C_FREEZE, S_WAIT_BR);
    tick(C_FREEZE, S_WAIT_BR);
    hz.mem_busy = 1'b0;
    tick(C_REDIR, S_WAIT_BR);
    tick(C_NORMAL, S_RECOVER);
    checks++;
    if (stall_cnt !== 16'(s0 + 3)) begin
      errors++; $display("FAIL busybr_stall got %0d expected %0d", stall_cnt, s0 + 3);
    end
    // freeze outranks a load-use hit; the hit is served once busy drops
    hz.mem_busy = 1'b1;
    hz.ex_memRead = 1'b1; hz.ex_S_regWrite = 1'b1; hz.ex_Sd = 3'd5; hz.id_Sm = 3'd5;
    tick(C_FREEZE, S_RUN);
    hz.mem_busy = 1'b0;
    tick(C_BUBBLE, S_WAIT);
    clearInputs();
    tick(C_NORMAL, S_RUN);
    // freeze during RECOVER with no branch goes to plain WAIT
    hz.mem_branchTaken = 1'b1;
    tick(C_REDIR, S_RUN);
    hz.mem_branchTaken = 1'b0; hz.mem_busy = 1'b1;
    tick(C_FREEZE, S_RECOVER);
    hz.mem_busy = 1'b0;
    tick(C_NORMAL, S_WAIT);
    tick(C_NORMAL, S_RUN);
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL busybr_timeout got %b expected 0", mem_timeout);
    end
  endtask

  task automatic test_timeout();
    clearInputs();
    // two runs of TIMEOUT-1 separated by one idle cycle: no timeout
    for (int r = 0; r < 2; r++) begin
      hz.mem_busy = 1'b1;
      tick(C_FREEZE, S_RUN);
      for (int i = 1; i < TIMEOUT - 1; i++) tick(C_FREEZE, S_WAIT);
      hz.mem_busy = 1'b0;
      tick(C_NORMAL, S_WAIT);
      checks++;
      if (mem_timeout !== 1'b0) begin
        errors++; $display("FAIL timeout_short%0d got %b expected 0", r, mem_timeout);
      end
    end
    hz.mem_busy = 1'b1;
    tick(C_FREEZE, S_RUN);
    for (int i = 1; i < TIMEOUT - 1; i++) tick(C_FREEZE, S_WAIT);
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early got %b expected 0", mem_timeout);
    end
    tick(C_FREEZE, S_WAIT);
    checks++;
    if (mem_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_set got %b expected 1", mem_timeout);
    end
    hz.mem_busy = 1'b0;
    tick(C_NORMAL, S_WAIT);
    checks++;
    if (mem_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got %b expected 1", mem_timeout);
    end
    clr_stats = 1'b1;
    tick(C_NORMAL, S_RUN);
    clr_stats = 1'b0;
    expStall = 0;
    checks++;
    if (mem_timeout !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL timeout_clear got to=%b stall=%0d expected 0/0", mem_timeout, stall_cnt);
    end
    // clear lands on the same edge as the timeout and a stall increment
    hz.mem_busy = 1'b1;
    tick(C_FREEZE, S_RUN);
    for (int i = 1; i < TIMEOUT - 1; i++) tick(C_FREEZE, S_WAIT);
    clr_stats = 1'b1;
    tick(C_FREEZE, S_WAIT);
    clr_stats = 1'b0;
    expStall = 0;
    checks++;
    if (mem_timeout !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL clear_wins got to=%b stall=%0d expected 0/0", mem_timeout, stall_cnt);
    end
    hz.mem_busy = 1'b0;
    tick(C_NORMAL, S_WAIT);
  endtask

  task automatic test_saturation_reset();
    clearInputs();
    hz.mem_busy = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL stall_saturate got %h expected ffff", stall_cnt);
    end
    hz.mem_branchTaken = 1'b1;
    @(posedge clk);
    #1;
    hz.mem_branchTaken = 1'b0;
    checks++;
    if (state !== S_WAIT_BR) begin
      errors++; $display("FAIL latch_branch got %b expected %b", state, S_WAIT_BR);
    end
    #2;
    reset = 1'b0;   // asynchronous, mid-cycle
    #1;
    checks++;
    if (state !== S_RUN || stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL async_reset got st=%b stall=%0d to=%b expected 00/0/0",
                         state, stall_cnt, mem_timeout);
    end
    hz.mem_busy = 1'b0;
    #1;
    checks++;
    if (hz.pcWrite !== 1'b1 || {hz.p2_flush, hz.p1_flush, hz.p0_flush} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got pc=%b fl=%b expected 1/000",
                         hz.pcWrite, {hz.p2_flush, hz.p1_flush, hz.p0_flush});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    expStall = 0;
    tick(C_NORMAL, S_RUN);   // latched branch discarded: no redirect
    tick(C_NORMAL, S_RUN);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (sbQ.size() > 0) begin
          monExp = sbQ.pop_front();
          monAct = {hz.pcWrite, hz.p3_we, hz.p2_we, hz.p1_we, hz.p0_we,
                    hz.p2_flush, hz.p1_flush, hz.p0_flush, state};
          checks++;
          if (monAct !== {monExp.ctl, monExp.st}) begin
            errors++;
            $display("FAIL sb_cycle%0d got pc_we_fl_st=%b_%b_%b_%b expected %b_%b_%b_%b",
                     sbCycle, monAct[9], monAct[8:5], monAct[4:2], monAct[1:0],
                     monExp.ctl[7], monExp.ctl[6:3], monExp.ctl[2:0], monExp.st);
          end
          sbCycle++;
        end
      end
    join_none

    test_reset();
    test_load_use();
    test_branch();
    test_busy_branch();
    test_timeout();
    test_saturation_reset();

    @(negedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d pending expected 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
